regfile_write_arbiter: RTL

//   Shares the single register-file write port between NUM_REQ writeback

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_if.sv | 32 +++
 rtl/regfile_write_arbiter_rr_priority_picker.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned BIT_WIDTH_DEF  = 32;
  localparam int unsigned REQ_IDX_W      = $clog2(NUM_REQ_DEF);

  // Widest supported requester count; onehot() is sized for it and callers truncate.
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_REQ);

  localparam int unsigned ZERO_REG = 0;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback-requester and register-file write-port bundle.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned BIT_WIDTH  = BIT_WIDTH_DEF
) ();

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic                            busy;
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_REQ*BIT_WIDTH-1:0]    req_data;
  logic [NUM_REQ-1:0]              ack;
  logic                            wr_en;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic [BIT_WIDTH-1:0]            wr_data;
  logic [IDX_W-1:0]                grant_id;

  modport master (
    output busy, req, req_addr, req_data,
    input  ack, wr_en, wr_addr, wr_data, grant_id
  );

  modport slave (
    input  busy, req, req_addr, req_data,
    output ack, wr_en, wr_addr, wr_data, grant_id
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
// Round-robin pick: lowest set bit at or above ptr, wrapping to bit 0.
module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_c,
  output logic [IW-1:0] winner_c
);

  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      hi_mask[i] = (IW'(i) >= ptr_i);
    end
  end

  // Upper copy is unmasked so the search wraps past N-1 back to 0.
  assign dbl     = {eligible_i, eligible_i & hi_mask};
  assign valid_c = |eligible_i;

  always_comb begin
    winner_c = '0;
    for (int i = 2 * int'(N) - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        winner_c = (i >= int'(N)) ? IW'(i - int'(N)) : IW'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one registered register-file write port.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int unsigned ZERO_DISCARD = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    ack_q,     ack_d;
  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BIT_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [IDX_W-1:0]      grant_q,   grant_d;
  logic [IDX_W-1:0]      ptr_q,     ptr_d;

  logic [NUM_REQ-1:0]    eligible;
  logic                  pick_valid;
  logic                  pick;
  logic [IDX_W-1:0]      winner;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [BIT_WIDTH-1:0]  win_data;

  // A requester being acked now still holds req; mask it to avoid a double serve.
  assign eligible = bus.req & ~ack_q;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .valid_c    (pick_valid),
    .winner_c   (winner)
  );

  assign pick     = pick_valid & ~bus.busy;
  assign win_addr = bus.req_addr[int'(winner) * ADDR_WIDTH +: ADDR_WIDTH];
  assign win_data = bus.req_data[int'(winner) * BIT_WIDTH +: BIT_WIDTH];

  always_comb begin
    ack_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    if (pick) begin
      ack_d     = NUM_REQ'(onehot(MAX_IDX_W'(winner)));
      wr_en_d   = !((ZERO_DISCARD != 0) && (win_addr == ADDR_WIDTH'(ZERO_REG)));
      wr_addr_d = win_addr;
      wr_data_d = win_data;
      grant_d   = winner;
      ptr_d     = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
    end else begin
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.grant_id = grant_q;

endmodule
